// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// FSM state encoding and the 3-sample majority vote.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Pin synchronizer, falling-edge detect, per-bit counter and 3-sample
// majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DIV         = 25,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    input  logic restart_i,
    output logic rx_s_o,
    output logic fall_o,
    output logic bit_val_o,
    output logic bit_strobe_o,
    output logic bit_end_o
);

    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_d_q;
    logic [CW-1:0]          cnt_q;
    logic                   s0_q;
    logic                   s1_q;
    logic                   rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            rx_d_q <= 1'b1;
            cnt_q  <= '0;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_d_q <= rx_s;
            if (restart_i || cnt_q == CW'(DIV - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q == CW'(HALF - 1)) s0_q <= rx_s;
            if (cnt_q == CW'(HALF))     s1_q <= rx_s;
        end
    end

    // Third sample is the live synchronized value in the decision cycle.
    assign rx_s_o       = rx_s;
    assign fall_o       = rx_d_q & ~rx_s;
    assign bit_val_o    = majority3(s0_q, s1_q, rx_s);
    assign bit_strobe_o = (cnt_q == CW'(HALF + 1));
    assign bit_end_o    = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register, parity and
// error/break reporting on top of uart_rx_sampler.
//   state     | meaning
//   IDLE      | waiting for a start edge
//   START     | start bit, glitch rejection at its decision cycle
//   DATA      | shifting data bits LSB first
//   PARITY    | capturing the parity bit
//   STOP      | stop bit(s); last decision ends the frame
//   BRK_WAIT  | break seen, waiting for the line to return high
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int FREQ        = 50_000_000,
    parameter int RATE        = 2_000_000,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_vld,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int         DIV      = FREQ / RATE;
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    state_t                 state_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [3:0]             bit_idx_q;
    logic                   par_acc_q;
    logic                   par_bit_q;
    logic                   stop_idx_q;
    logic                   ferr_acc_q;
    logic                   vld_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   brk_q;

    logic rx_s, fall, bit_val, bit_strobe, bit_end, restart;
    logic is_break, last_stop, par_x, parity_bad;

    assign restart = (state_q == ST_IDLE) && fall;

    uart_rx_sampler #(
        .DIV         (DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (i_rx),
        .restart_i    (restart),
        .rx_s_o       (rx_s),
        .fall_o       (fall),
        .bit_val_o    (bit_val),
        .bit_strobe_o (bit_strobe),
        .bit_end_o    (bit_end)
    );

    assign par_x      = par_acc_q ^ par_bit_q;
    assign parity_bad = (PARITY == PARITY_ODD)  ? ~par_x :
                        (PARITY == PARITY_EVEN) ?  par_x : 1'b0;
    assign last_stop  = (STOP_BITS == 1) || stop_idx_q;
    assign is_break   = (shreg_q == '0) && (PARITY == PARITY_NONE || !par_bit_q)
                        && !bit_val && !stop_idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            data_q     <= '0;
            bit_idx_q  <= '0;
            par_acc_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            vld_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            vld_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            brk_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (fall) state_q <= ST_START;
                end
                ST_START: begin
                    if (bit_strobe && bit_val) begin
                        state_q <= ST_IDLE;
                    end else if (bit_end) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        par_acc_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bit_strobe) begin
                        shreg_q   <= {bit_val, shreg_q[DATA_BITS-1:1]};
                        par_acc_q <= par_acc_q ^ bit_val;
                    end
                    if (bit_end) begin
                        if (bit_idx_q == BIT_LAST) begin
                            state_q    <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            stop_idx_q <= 1'b0;
                            ferr_acc_q <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_strobe) par_bit_q <= bit_val;
                    if (bit_end)    state_q   <= ST_STOP;
                end
                ST_STOP: begin
                    // Leave at the decision cycle so an early next start edge is caught.
                    if (bit_strobe) begin
                        if (is_break) begin
                            brk_q   <= 1'b1;
                            state_q <= ST_BRK_WAIT;
                        end else if (last_stop) begin
                            vld_q   <= 1'b1;
                            data_q  <= shreg_q;
                            perr_q  <= parity_bad;
                            ferr_q  <= ferr_acc_q | ~bit_val;
                            state_q <= ST_IDLE;
                        end else begin
                            ferr_acc_q <= ~bit_val;
                        end
                    end else if (bit_end) begin
                        stop_idx_q <= 1'b1;
                    end
                end
                ST_BRK_WAIT: begin
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_data       = data_q;
    assign o_vld        = vld_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_break      = brk_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
